// File: rtl/core_rot_pkg.sv
// core_rot_pkg: shared types for the tile rotation address generator.
// Holds the controller state encoding, the DEGREES input encodings and the
// quarter-turn code type with its conversion helper.
package core_rot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] P_DEG_0   = 2'd0;
  localparam logic [1:0] P_DEG_90  = 2'd1;
  localparam logic [1:0] P_DEG_180 = 2'd2;
  localparam logic [1:0] P_DEG_270 = 2'd3;

  // Number of counter-clockwise quarter turns, 0..3.
  typedef logic [1:0] qturn_t;

  // Clockwise rotation by d is the same as counter-clockwise by (4 - d) mod 4,
  // which in two bits is just the negation of d.
  function automatic qturn_t quarter_turns(input logic [1:0] degrees, input logic ccw);
    return ccw ? qturn_t'(degrees) : qturn_t'(2'd0 - degrees);
  endfunction

endpackage

// File: rtl/core_rot_dst.sv
// core_rot_dst: destination address walker for one tile.
// Tracks raster row/column of the source pixel and produces the per-channel
// output-buffer byte addresses for the rotated (and optionally mirrored)
// position using only constant adds, so no multiplier is needed.
// Addresses are held at zero whenever neither init_i nor step_i is asserted.
module core_rot_dst
  import core_rot_pkg::*;
#(
  parameter int TILE_W = 8,
  parameter int TILE_H = 8,
  parameter int BPP    = 3,
  parameter int AW     = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              init_i,
  input  logic              step_i,
  input  qturn_t            k_i,
  input  logic              mirror_i,
  output logic [BPP*AW-1:0] dst_o,
  output logic              last_o
);

  localparam int CW = $clog2(TILE_W);
  localparam int RW = $clog2(TILE_H);

  localparam logic [AW-1:0] ZERO   = '0;
  localparam logic [AW-1:0] S_PX   = AW'(BPP);
  localparam logic [AW-1:0] S_ROWW = AW'(TILE_W * BPP);
  localparam logic [AW-1:0] S_ROWH = AW'(TILE_H * BPP);
  localparam logic [AW-1:0] A_HM1  = AW'((TILE_H - 1) * BPP);
  localparam logic [AW-1:0] A_WM1  = AW'((TILE_W - 1) * BPP);
  localparam logic [AW-1:0] A_LAST = AW'((TILE_W * TILE_H - 1) * BPP);
  localparam logic [AW-1:0] A_K3   = AW'((TILE_W - 1) * TILE_H * BPP);
  localparam logic [AW-1:0] A_M2   = AW'((TILE_H - 1) * TILE_W * BPP);

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [AW-1:0]          rowbase_q, rowbase_d;
  logic [AW-1:0]          base_d;
  logic [AW-1:0]          start_v, colstep_v, rowstep_v;
  logic [BPP-1:0][AW-1:0] slc_q, slc_d;
  logic                   col_last;

  // Per-orientation start address, step along a source row, and step between
  // consecutive source row starts (negative steps wrap modulo 2^AW).
  always_comb begin
    start_v   = ZERO;
    colstep_v = S_PX;
    rowstep_v = S_ROWW;
    unique case ({mirror_i, k_i})
      3'b000: begin start_v = ZERO;   colstep_v = S_PX;          rowstep_v = S_ROWW;        end
      3'b001: begin start_v = A_HM1;  colstep_v = S_ROWH;        rowstep_v = ZERO - S_PX;   end
      3'b010: begin start_v = A_LAST; colstep_v = ZERO - S_PX;   rowstep_v = ZERO - S_ROWW; end
      3'b011: begin start_v = A_K3;   colstep_v = ZERO - S_ROWH; rowstep_v = S_PX;          end
      3'b100: begin start_v = A_WM1;  colstep_v = ZERO - S_PX;   rowstep_v = S_ROWW;        end
      3'b101: begin start_v = ZERO;   colstep_v = S_ROWH;        rowstep_v = S_PX;          end
      3'b110: begin start_v = A_M2;   colstep_v = S_PX;          rowstep_v = ZERO - S_ROWW; end
      3'b111: begin start_v = A_LAST; colstep_v = ZERO - S_ROWH; rowstep_v = ZERO - S_PX;   end
      default: ;
    endcase
  end

  assign col_last = (col_q == CW'(TILE_W - 1));
  assign last_o   = col_last && (row_q == RW'(TILE_H - 1));

  // Advance the walker: restart on init, move one source pixel on step,
  // otherwise park everything at zero.
  always_comb begin
    col_d     = '0;
    row_d     = '0;
    rowbase_d = '0;
    base_d    = '0;
    if (init_i) begin
      rowbase_d = start_v;
      base_d    = start_v;
    end else if (step_i) begin
      if (col_last) begin
        row_d     = row_q + RW'(1);
        rowbase_d = rowbase_q + rowstep_v;
        base_d    = rowbase_q + rowstep_v;
      end else begin
        col_d     = col_q + CW'(1);
        row_d     = row_q;
        rowbase_d = rowbase_q;
        base_d    = slc_q[0] + colstep_v;
      end
    end
    for (int ch = 0; ch < BPP; ch++) begin
      slc_d[ch] = (init_i || step_i) ? base_d + AW'(ch) : '0;
    end
  end

  // Walker state and registered per-channel destination addresses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q     <= '0;
      row_q     <= '0;
      rowbase_q <= '0;
      slc_q     <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      rowbase_q <= rowbase_d;
      slc_q     <= slc_d;
    end
  end

  assign dst_o = slc_q;

endmodule

// File: rtl/core_rot_addr.sv
// core_rot_addr: address generator for a tile rotation engine.
// Sequences LOAD (DMA into input buffer), XFER (one pixel per cycle from the
// input buffer to its rotated slot in the output buffer) and DRAIN (DMA out)
// for each tile of a job. Optional feature macro: ROT_MIRROR_EN adds the
// I_RA_MIRROR input for a horizontal flip after rotation.
module core_rot_addr
  import core_rot_pkg::*;
#(
  parameter int TILE_W    = 8,
  parameter int TILE_H    = 8,
  parameter int BPP       = 3,
  parameter int BUS_BYTES = 4,
  parameter int AW        = 8
) (
  input  logic              I_RA_HCLK,
  input  logic              I_RA_HRESET_N,
  input  logic              I_RA_START,
  input  logic              I_RA_ABORT,
  input  logic [15:0]       I_RA_TILES,
  input  logic [1:0]        I_RA_DEGREES,
  input  logic              I_RA_DIRECTION,
`ifdef ROT_MIRROR_EN
  input  logic              I_RA_MIRROR,
`endif
  input  logic              I_RA_DMA_READY,
  output logic [AW-1:0]     O_RA_IN_WADDR,
  output logic              O_RA_IN_WEN,
  output logic [BPP*AW-1:0] O_RA_SRC_ADDR,
  output logic [BPP*AW-1:0] O_RA_DST_ADDR,
  output logic              O_RA_XFER_VLD,
  output logic [AW-1:0]     O_RA_OUT_RADDR,
  output logic              O_RA_OUT_REN,
  output logic              O_RA_BUSY,
  output logic              O_RA_DONE
);

  localparam logic [AW-1:0] LAST_BEAT = AW'(TILE_W * TILE_H * BPP - BUS_BYTES);
  localparam logic [AW-1:0] STEP_BEAT = AW'(BUS_BYTES);
  localparam logic [AW-1:0] STEP_PX   = AW'(BPP);

  state_e                 state_q, state_d;
  logic [15:0]            tiles_q, tiles_d;
  qturn_t                 k_q, k_d;
  logic                   mirror_q, mirror_d, mirror_in;
  logic [AW-1:0]          waddr_q, waddr_d, raddr_q, raddr_d;
  logic [BPP-1:0][AW-1:0] src_q, src_d;
  logic [AW-1:0]          src_base_d;
  logic                   wen_q, ren_q, xvld_q, busy_q, done_q, done_d;
  logic                   load_last, drain_last, dst_last, dst_init, dst_step;

`ifdef ROT_MIRROR_EN
  assign mirror_in = I_RA_MIRROR;
`else
  assign mirror_in = 1'b0;
`endif

  // Next-state, job configuration capture and address counter updates.
  always_comb begin
    state_d    = state_q;
    tiles_d    = tiles_q;
    k_d        = k_q;
    mirror_d   = mirror_q;
    done_d     = 1'b0;
    load_last  = (state_q == ST_LOAD)  && I_RA_DMA_READY && (waddr_q == LAST_BEAT);
    drain_last = (state_q == ST_DRAIN) && I_RA_DMA_READY && (raddr_q == LAST_BEAT);
    unique case (state_q)
      ST_IDLE: begin
        if (I_RA_START && !I_RA_ABORT) begin
          tiles_d  = I_RA_TILES;
          k_d      = quarter_turns(I_RA_DEGREES, I_RA_DIRECTION);
          mirror_d = mirror_in;
          if (I_RA_TILES != 16'd0) state_d = ST_LOAD;
          else                     done_d  = 1'b1;
        end
      end
      ST_LOAD:  if (load_last) state_d = ST_XFER;
      ST_XFER:  if (dst_last)  state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (drain_last) begin
          if (tiles_q > 16'd1) begin
            tiles_d = tiles_q - 16'd1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (I_RA_ABORT) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end

    waddr_d = '0;
    if (state_q == ST_LOAD && state_d == ST_LOAD)
      waddr_d = I_RA_DMA_READY ? waddr_q + STEP_BEAT : waddr_q;
    raddr_d = '0;
    if (state_q == ST_DRAIN && state_d == ST_DRAIN)
      raddr_d = I_RA_DMA_READY ? raddr_q + STEP_BEAT : raddr_q;

    src_base_d = (state_q == ST_XFER && state_d == ST_XFER) ? src_q[0] + STEP_PX : '0;
    for (int ch = 0; ch < BPP; ch++) begin
      src_d[ch] = (state_d == ST_XFER) ? src_base_d + AW'(ch) : '0;
    end

    dst_init = (state_q != ST_XFER) && (state_d == ST_XFER);
    dst_step = (state_q == ST_XFER) && (state_d == ST_XFER);
  end

  // Controller state, latched job configuration and registered outputs.
  always_ff @(posedge I_RA_HCLK or negedge I_RA_HRESET_N) begin
    if (!I_RA_HRESET_N) begin
      state_q  <= ST_IDLE;
      tiles_q  <= '0;
      k_q      <= '0;
      mirror_q <= 1'b0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      src_q    <= '0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      xvld_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tiles_q  <= tiles_d;
      k_q      <= k_d;
      mirror_q <= mirror_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      src_q    <= src_d;
      wen_q    <= (state_d == ST_LOAD);
      ren_q    <= (state_d == ST_DRAIN);
      xvld_q   <= (state_d == ST_XFER);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= done_d;
    end
  end

  core_rot_dst #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H),
    .BPP    (BPP),
    .AW     (AW)
  ) u_dst (
    .clk_i    (I_RA_HCLK),
    .rst_ni   (I_RA_HRESET_N),
    .init_i   (dst_init),
    .step_i   (dst_step),
    .k_i      (k_q),
    .mirror_i (mirror_q),
    .dst_o    (O_RA_DST_ADDR),
    .last_o   (dst_last)
  );

  assign O_RA_IN_WADDR  = waddr_q;
  assign O_RA_IN_WEN    = wen_q;
  assign O_RA_SRC_ADDR  = src_q;
  assign O_RA_XFER_VLD  = xvld_q;
  assign O_RA_OUT_RADDR = raddr_q;
  assign O_RA_OUT_REN   = ren_q;
  assign O_RA_BUSY      = busy_q;
  assign O_RA_DONE      = done_q;

endmodule

// File: tb/tb_core_rot_addr.sv
// tb_core_rot_addr: self-checking bench for core_rot_addr at default
// parameters. A behavioural model computes rotated pixel positions directly
// from row/column geometry; jobs use randomized orientation and DMA handshakes.
module tb_core_rot_addr;

  localparam int TILE_W    = 8;
  localparam int TILE_H    = 8;
  localparam int BPP       = 3;
  localparam int BUS_BYTES = 4;
  localparam int AW        = 8;
  localparam int NPIX      = TILE_W * TILE_H;
  localparam int NBYTES    = NPIX * BPP;

  logic              I_RA_HCLK;
  logic              I_RA_HRESET_N;
  logic              I_RA_START;
  logic              I_RA_ABORT;
  logic [15:0]       I_RA_TILES;
  logic [1:0]        I_RA_DEGREES;
  logic              I_RA_DIRECTION;
  logic              I_RA_MIRROR;
  logic              I_RA_DMA_READY;
  logic [AW-1:0]     O_RA_IN_WADDR;
  logic              O_RA_IN_WEN;
  logic [BPP*AW-1:0] O_RA_SRC_ADDR;
  logic [BPP*AW-1:0] O_RA_DST_ADDR;
  logic              O_RA_XFER_VLD;
  logic [AW-1:0]     O_RA_OUT_RADDR;
  logic              O_RA_OUT_REN;
  logic              O_RA_BUSY;
  logic              O_RA_DONE;

  int checks   = 0;
  int failures = 0;

  core_rot_addr #(
    .TILE_W(TILE_W), .TILE_H(TILE_H), .BPP(BPP), .BUS_BYTES(BUS_BYTES), .AW(AW)
  ) dut (
    .I_RA_HCLK      (I_RA_HCLK),
    .I_RA_HRESET_N  (I_RA_HRESET_N),
    .I_RA_START     (I_RA_START),
    .I_RA_ABORT     (I_RA_ABORT),
    .I_RA_TILES     (I_RA_TILES),
    .I_RA_DEGREES   (I_RA_DEGREES),
    .I_RA_DIRECTION (I_RA_DIRECTION),
`ifdef ROT_MIRROR_EN
    .I_RA_MIRROR    (I_RA_MIRROR),
`endif
    .I_RA_DMA_READY (I_RA_DMA_READY),
    .O_RA_IN_WADDR  (O_RA_IN_WADDR),
    .O_RA_IN_WEN    (O_RA_IN_WEN),
    .O_RA_SRC_ADDR  (O_RA_SRC_ADDR),
    .O_RA_DST_ADDR  (O_RA_DST_ADDR),
    .O_RA_XFER_VLD  (O_RA_XFER_VLD),
    .O_RA_OUT_RADDR (O_RA_OUT_RADDR),
    .O_RA_OUT_REN   (O_RA_OUT_REN),
    .O_RA_BUSY      (O_RA_BUSY),
    .O_RA_DONE      (O_RA_DONE)
  );

  initial I_RA_HCLK = 1'b0;
  always #5 I_RA_HCLK = ~I_RA_HCLK;

  task automatic tick();
    @(posedge I_RA_HCLK);
    #1;
  endtask

  function automatic bit outputs_zero();
    return ({O_RA_IN_WADDR, O_RA_IN_WEN, O_RA_SRC_ADDR, O_RA_DST_ADDR, O_RA_XFER_VLD,
             O_RA_OUT_RADDR, O_RA_OUT_REN, O_RA_BUSY, O_RA_DONE} === '0);
  endfunction

  // Byte address of the rotated/mirrored destination of source pixel (r, c).
  function automatic int model_dst(int r, int c, int k, int m);
    int row, col, width;
    case (k)
      0:       begin row = r;              col = c;              width = TILE_W; end
      1:       begin row = c;              col = TILE_H - 1 - r; width = TILE_H; end
      2:       begin row = TILE_H - 1 - r; col = TILE_W - 1 - c; width = TILE_W; end
      default: begin row = TILE_W - 1 - c; col = r;              width = TILE_H; end
    endcase
    if (m != 0) col = width - 1 - col;
    return (row * width + col) * BPP;
  endfunction

  function automatic logic pick_ready(int rmode, int cyc);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return (cyc % 2) == 1;
    return 1'($urandom);
  endfunction

  // One DMA phase: walks beats at BUS_BYTES stride until the final beat is
  // accepted, checking the address and strobe every cycle.
  task automatic dma_phase(input bit is_load, input int tile, input int rmode,
                           output int cycles, output bit ok);
    int ew;
    logic ready;
    logic [AW-1:0] got, exp;
    logic en;
    ew = 0; cycles = 0; ok = 1'b0;
    while (1) begin
      got = is_load ? O_RA_IN_WADDR : O_RA_OUT_RADDR;
      en  = is_load ? O_RA_IN_WEN : O_RA_OUT_REN;
      exp = AW'(ew);
      checks++;
      if (got !== exp || en !== 1'b1 || (is_load ? O_RA_OUT_REN : O_RA_IN_WEN) !== 1'b0 ||
          O_RA_XFER_VLD !== 1'b0 || O_RA_BUSY !== 1'b1 || O_RA_DONE !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s_beat tile=%0d cyc=%0d: got addr=%0d en=%b busy=%b done=%b, expected addr=%0d en=1 busy=1 done=0",
                 is_load ? "load" : "drain", tile, cycles, got, en, O_RA_BUSY, O_RA_DONE, exp);
      end
      if (cycles >= 1000) begin
        failures++;
        $display("[TB] FAIL %s_timeout tile=%0d: final beat not reached in 1000 cycles",
                 is_load ? "load" : "drain", tile);
        return;
      end
      ready = pick_ready(rmode, cycles);
      I_RA_DMA_READY = ready;
      tick();
      cycles++;
      if (ready) begin
        if (ew == NBYTES - BUS_BYTES) break;
        ew += BUS_BYTES;
      end
    end
    I_RA_DMA_READY = 1'b0;
    ok = 1'b1;
  endtask

  // Complete job against the model; reports first-tile load length and the
  // first two destination base addresses.
  task automatic run_job(input int tiles, input int deg, input int dir, input int mir,
                         input int rmode, output int load_cycles,
                         output int first_dst, output int second_dst);
    int k, em, cyc, r, c;
    bit ok, pix_ok;
    logic [AW-1:0] es, ed;
    k = (dir != 0) ? deg : (4 - deg) % 4;
`ifdef ROT_MIRROR_EN
    em = mir;
`else
    em = 0;
`endif
    load_cycles = 0; first_dst = -1; second_dst = -1;
    I_RA_TILES = 16'(tiles); I_RA_DEGREES = 2'(deg); I_RA_DIRECTION = 1'(dir);
    I_RA_MIRROR = 1'(mir); I_RA_START = 1'b1;
    tick();
    I_RA_START = 1'b0;
    I_RA_TILES = 16'($urandom); I_RA_DEGREES = 2'($urandom);
    I_RA_DIRECTION = 1'($urandom); I_RA_MIRROR = 1'($urandom);
    for (int t = 0; t < tiles; t++) begin
      dma_phase(1'b1, t, rmode, cyc, ok);
      if (!ok) return;
      if (t == 0) load_cycles = cyc;
      for (int p = 0; p < NPIX; p++) begin
        r = p / TILE_W;
        c = p % TILE_W;
        pix_ok = (O_RA_XFER_VLD === 1'b1) && (O_RA_IN_WEN === 1'b0) &&
                 (O_RA_OUT_REN === 1'b0) && (O_RA_BUSY === 1'b1);
        for (int ch = 0; ch < BPP; ch++) begin
          es = AW'(p * BPP + ch);
          ed = AW'(model_dst(r, c, k, em) + ch);
          if (O_RA_SRC_ADDR[ch*AW +: AW] !== es || O_RA_DST_ADDR[ch*AW +: AW] !== ed) pix_ok = 1'b0;
        end
        checks++;
        if (!pix_ok) begin
          failures++;
          $display("[TB] FAIL xfer_pixel tile=%0d r=%0d c=%0d k=%0d: got vld=%b src0=%0d dst0=%0d, expected vld=1 src0=%0d dst0=%0d",
                   t, r, c, k, O_RA_XFER_VLD, O_RA_SRC_ADDR[AW-1:0], O_RA_DST_ADDR[AW-1:0],
                   p * BPP, model_dst(r, c, k, em));
        end
        if (t == 0 && p == 0) first_dst  = int'(O_RA_DST_ADDR[AW-1:0]);
        if (t == 0 && p == 1) second_dst = int'(O_RA_DST_ADDR[AW-1:0]);
        I_RA_DMA_READY = 1'($urandom);
        I_RA_START     = 1'($urandom);
        tick();
      end
      I_RA_START = 1'b0;
      dma_phase(1'b0, t, rmode, cyc, ok);
      if (!ok) return;
    end
    checks++;
    if (O_RA_DONE !== 1'b1 || O_RA_BUSY !== 1'b0 || O_RA_XFER_VLD !== 1'b0 || O_RA_OUT_REN !== 1'b0) begin
      failures++;
      $display("[TB] FAIL job_done: got done=%b busy=%b, expected done=1 busy=0", O_RA_DONE, O_RA_BUSY);
    end
    tick();
    checks++;
    if (O_RA_DONE !== 1'b0 || O_RA_BUSY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_pulse_width: got done=%b busy=%b, expected done=0 busy=0", O_RA_DONE, O_RA_BUSY);
    end
  endtask

  task automatic test_reset();
    I_RA_HRESET_N = 1'b0; I_RA_START = 1'b0; I_RA_ABORT = 1'b0; I_RA_TILES = 16'd0;
    I_RA_DEGREES = 2'd0; I_RA_DIRECTION = 1'b0; I_RA_MIRROR = 1'b0; I_RA_DMA_READY = 1'b0;
    #12;
    checks++;
    if (!outputs_zero()) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got busy=%b wen=%b waddr=%0d, expected all zero", O_RA_BUSY, O_RA_IN_WEN, O_RA_IN_WADDR);
    end
    tick();
    I_RA_HRESET_N = 1'b1;
    I_RA_DMA_READY = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (!outputs_zero()) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got busy=%b wen=%b, expected all zero", O_RA_BUSY, O_RA_IN_WEN);
    end
    I_RA_DMA_READY = 1'b0;
  endtask

  task automatic test_load_ready_high();
    int lc, f, s;
    run_job(1, 0, 1, 0, 0, lc, f, s);
    checks++;
    if (lc != 48) begin
      failures++;
      $display("[TB] FAIL load_len_ready_high: got %0d cycles, expected 48", lc);
    end
  endtask

  task automatic test_load_toggle();
    int lc, f, s;
    run_job(1, 2, 0, 0, 1, lc, f, s);
    checks++;
    if (lc != 96) begin
      failures++;
      $display("[TB] FAIL load_len_toggle: got %0d cycles, expected 96", lc);
    end
  endtask

  task automatic test_rotation_codes();
    int lc, f, s;
    run_job(1, 1, 1, 0, 2, lc, f, s);
    checks++;
    if (f != 'h15 || s != 'h2D) begin
      failures++;
      $display("[TB] FAIL ccw90_first_dst: got %0h,%0h, expected 15,2d", f, s);
    end
    run_job(1, 2, 1, 0, 2, lc, f, s);
    checks++;
    if (f != 'hBD) begin
      failures++;
      $display("[TB] FAIL ccw180_first_dst: got %0h, expected bd", f);
    end
    run_job(1, 1, 0, 0, 2, lc, f, s);
    checks++;
    if (f != 'hA8) begin
      failures++;
      $display("[TB] FAIL cw90_first_dst: got %0h, expected a8", f);
    end
  endtask

  task automatic test_random_jobs();
    int lc, f, s;
    for (int j = 0; j < 5; j++) begin
      run_job(1 + int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 2, lc, f, s);
    end
  endtask

  task automatic test_back_to_back();
    int lc, f, s;
    run_job(2, 3, 1, 0, 2, lc, f, s);
  endtask

  task automatic test_zero_tiles();
    I_RA_TILES = 16'd0; I_RA_START = 1'b1;
    tick();
    I_RA_START = 1'b0;
    checks++;
    if (O_RA_DONE !== 1'b1 || O_RA_BUSY !== 1'b0 || O_RA_IN_WEN !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_tiles_done: got done=%b busy=%b wen=%b, expected done=1 busy=0 wen=0", O_RA_DONE, O_RA_BUSY, O_RA_IN_WEN);
    end
    tick();
    checks++;
    if (!outputs_zero()) begin
      failures++;
      $display("[TB] FAIL zero_tiles_after: got done=%b busy=%b, expected all zero", O_RA_DONE, O_RA_BUSY);
    end
  endtask

  task automatic test_abort();
    int n;
    bit saw_done, saw_busy;
    I_RA_TILES = 16'd3; I_RA_DEGREES = 2'd1; I_RA_DIRECTION = 1'b1; I_RA_START = 1'b1;
    I_RA_DMA_READY = 1'b1;
    tick();
    I_RA_START = 1'b0;
    n = 0;
    while (O_RA_XFER_VLD !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (O_RA_XFER_VLD !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_reach_xfer: got xfer_vld=%b, expected 1 within 300 cycles", O_RA_XFER_VLD);
    end
    for (int i = 0; i < 5; i++) tick();
    I_RA_ABORT = 1'b1;
    tick();
    I_RA_ABORT = 1'b0;
    checks++;
    if (!outputs_zero()) begin
      failures++;
      $display("[TB] FAIL abort_idle: got busy=%b xfer_vld=%b done=%b dst0=%0d, expected all zero", O_RA_BUSY, O_RA_XFER_VLD, O_RA_DONE, O_RA_DST_ADDR[AW-1:0]);
    end
    saw_done = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      saw_done |= O_RA_DONE;
      saw_busy |= O_RA_BUSY;
    end
    checks++;
    if (saw_done || saw_busy) begin
      failures++;
      $display("[TB] FAIL abort_quiet: got done_seen=%b busy_seen=%b, expected 0 0", saw_done, saw_busy);
    end
    I_RA_START = 1'b1; I_RA_ABORT = 1'b1; I_RA_TILES = 16'd1;
    tick();
    I_RA_START = 1'b0; I_RA_ABORT = 1'b0;
    tick();
    checks++;
    if (!outputs_zero()) begin
      failures++;
      $display("[TB] FAIL abort_beats_start: got busy=%b wen=%b, expected all zero", O_RA_BUSY, O_RA_IN_WEN);
    end
    I_RA_DMA_READY = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int n;
    I_RA_TILES = 16'd1; I_RA_DEGREES = 2'd0; I_RA_DIRECTION = 1'b0; I_RA_START = 1'b1;
    I_RA_DMA_READY = 1'b1;
    tick();
    I_RA_START = 1'b0;
    n = 0;
    while (O_RA_OUT_REN !== 1'b1 && n < 400) begin tick(); n++; end
    tick(); tick(); tick();
    checks++;
    if (O_RA_OUT_REN !== 1'b1 || O_RA_OUT_RADDR !== AW'(3 * BUS_BYTES)) begin
      failures++;
      $display("[TB] FAIL drain_before_reset: got ren=%b raddr=%0d, expected ren=1 raddr=%0d", O_RA_OUT_REN, O_RA_OUT_RADDR, 3 * BUS_BYTES);
    end
    #2;
    I_RA_HRESET_N = 1'b0;
    #1;
    checks++;
    if (!outputs_zero()) begin
      failures++;
      $display("[TB] FAIL reset_mid_drain: got ren=%b raddr=%0d busy=%b, expected all zero", O_RA_OUT_REN, O_RA_OUT_RADDR, O_RA_BUSY);
    end
    #3;
    I_RA_HRESET_N = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (!outputs_zero()) begin
      failures++;
      $display("[TB] FAIL quiet_after_reset: got busy=%b wen=%b, expected all zero", O_RA_BUSY, O_RA_IN_WEN);
    end
    I_RA_DMA_READY = 1'b0;
  endtask

`ifdef ROT_MIRROR_EN
  task automatic test_mirror();
    int lc, f, s;
    run_job(1, 0, 1, 1, 0, lc, f, s);
    checks++;
    if (f != 'h15) begin
      failures++;
      $display("[TB] FAIL mirror_first_dst: got %0h, expected 15", f);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_ready_high();
    test_load_toggle();
    test_rotation_codes();
    test_zero_tiles();
    test_back_to_back();
    test_random_jobs();
    test_abort();
`ifdef ROT_MIRROR_EN
    test_mirror();
`endif
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
